// File: rtl/spi_ram_target_if.sv
// spi_ram_target_if: SPI pin bundle between the initiator and the serial RAM target
interface spi_ram_target_if;
    logic spi_clk;
    logic spi_select;
    logic spi_mosi;
    logic spi_miso;
    modport master (output spi_clk, spi_select, spi_mosi, input spi_miso);
    modport slave (input spi_clk, spi_select, spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_ram_target.sv
// spi_ram_target: oversampled SPI serial-SRAM responder (READ 0x03 / WRITE 0x02) over a byte memory
module spi_ram_target #(
    parameter int MEM_ADDR_BITS = 8,
    parameter int ADDR_BITS = 16
) (
    input  logic clk,
    input  logic rst,
    spi_ram_target_if.slave spi,
    output logic active,
    output logic bad_cmd,
    input  logic [MEM_ADDR_BITS-1:0] dbg_addr,
    output logic [7:0] dbg_data
);
    localparam int SW = ADDR_BITS > 8 ? ADDR_BITS : 8;
    localparam int CW = $clog2(SW);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, IGNORE} state_t;
    state_t state, state_n;
    logic [2:0] sync1, sync2;
    logic [1:0] hist;
    logic [1:0] settle;
    logic armed;
    logic [CW-1:0] cnt, cnt_n;
    logic [SW-1:0] sh, sh_n, nxt;
    logic [MEM_ADDR_BITS-1:0] addr, addr_n, addr_in, addr_inc;
    logic op_rd, op_rd_n, miso, miso_n, bad_n, mem_we;
    logic sclk_rise, sclk_fall, sel_rise, sel_fall;
    logic [7:0] mem [2**MEM_ADDR_BITS];
    assign sclk_rise = !hist[1] && sync2[2];
    assign sclk_fall = hist[1] && !sync2[2];
    assign sel_rise = !hist[0] && sync2[1];
    assign sel_fall = hist[0] && !sync2[1];
    assign nxt = SW'({sh, sync2[0]});
    assign addr_in = MEM_ADDR_BITS'(nxt);
    assign addr_inc = addr + MEM_ADDR_BITS'(1);
    assign dbg_data = mem[dbg_addr];
    assign spi.spi_miso = miso;
    // armed stays low after reset until select has really been sampled high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 3'b010;
            sync2 <= 3'b010;
            hist <= 2'b01;
            settle <= '0;
            armed <= 1'b0;
            active <= 1'b0;
            state <= IDLE;
            cnt <= '0;
            sh <= '0;
            addr <= '0;
            op_rd <= 1'b0;
            miso <= 1'b0;
            bad_cmd <= 1'b0;
        end else begin
            sync1 <= {spi.spi_clk, spi.spi_select, spi.spi_mosi};
            sync2 <= sync1;
            hist <= sync2[2:1];
            settle <= settle + {1'b0, ~settle[1]};
            armed <= armed | (settle[1] & sync2[1]);
            active <= !sync2[1];
            state <= state_n;
            cnt <= cnt_n;
            sh <= sh_n;
            addr <= addr_n;
            op_rd <= op_rd_n;
            miso <= miso_n;
            bad_cmd <= bad_n;
        end
    end
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr] <= nxt[7:0];
    end
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        sh_n = sh;
        addr_n = addr;
        op_rd_n = op_rd;
        miso_n = miso;
        bad_n = 1'b0;
        mem_we = 1'b0;
        if (sel_rise) begin
            state_n = IDLE;
            miso_n = 1'b0;
        end else begin
            case (state)
                IDLE: if (sel_fall && armed) begin
                    state_n = CMD;
                    cnt_n = '0;
                end
                CMD: if (sclk_rise) begin
                    sh_n = nxt;
                    cnt_n = cnt + CW'(1);
                    if (cnt == CW'(7)) begin
                        cnt_n = '0;
                        op_rd_n = nxt[7:0] == 8'h03;
                        bad_n = (nxt[7:0] != 8'h03) && (nxt[7:0] != 8'h02);
                        state_n = bad_n ? IGNORE : ADDR;
                    end
                end
                ADDR: if (sclk_rise) begin
                    sh_n = nxt;
                    cnt_n = cnt + CW'(1);
                    if (cnt == CW'(ADDR_BITS - 1)) begin
                        cnt_n = '0;
                        addr_n = addr_in;
                        state_n = op_rd ? READ : WRITE;
                        sh_n = op_rd ? SW'(mem[addr_in]) : nxt;
                    end
                end
                // the fall that shifts out bit 0 also prefetches the following byte
                READ: if (sclk_fall) begin
                    miso_n = sh[7];
                    sh_n = sh << 1;
                    cnt_n = cnt + CW'(1);
                    if (cnt == CW'(7)) begin
                        cnt_n = '0;
                        addr_n = addr_inc;
                        sh_n = SW'(mem[addr_inc]);
                    end
                end
                WRITE: if (sclk_rise) begin
                    sh_n = nxt;
                    cnt_n = cnt + CW'(1);
                    if (cnt == CW'(7)) begin
                        cnt_n = '0;
                        mem_we = 1'b1;
                        addr_n = addr_inc;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
